// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states,
// step count and the operand-magnitude helper.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam int MDU_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  // Magnitude of a signed operand; unsigned operands pass through untouched.
  function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      mdu_mag = 32'd0 - v;
    end else begin
      mdu_mag = v;
    end
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract for divide.
// The accumulator holds {partial, multiplier} or {remainder, dividend/quotient}.
module mdu_step
  import mdu_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] add_s;
  logic [32:0] shifted_s;
  logic [32:0] sub_s;
  logic        borrow_s;

  // Single-iteration datapath; the shifted remainder can exceed 32 bits, in which
  // case the subtract can never borrow because the divisor fits in 32 bits.
  always_comb begin
    add_s     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    shifted_s = {acc[63:32], acc[31]};
    sub_s     = shifted_s - {1'b0, opnd};
    borrow_s  = sub_s[32] & ~shifted_s[32];
    if (is_div) begin
      if (borrow_s) begin
        acc_next = {shifted_s[31:0], acc[30:0], 1'b0};
      end else begin
        acc_next = {sub_s[31:0], acc[30:0], 1'b1};
      end
    end else begin
      acc_next = {add_s, acc[31:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with architectural HI/LO; fixed 33-cycle latency
// per operation, busy held high from the start edge through the result edge.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        divz_q, divz_d;
  logic [31:0] a_org_q, a_org_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] step_acc_s;
  logic [63:0] prod_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic        is_signed_s;

  mdu_step u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (step_acc_s)
  );

  // Next-state logic: launch, iterate, sign-fix, plus idle mthi/mtlo writes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    is_div_d    = is_div_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    divz_d      = divz_q;
    a_org_d     = a_org_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    is_signed_s = ~op[0];
    a_mag_s     = mdu_mag(a, is_signed_s);
    b_mag_s     = mdu_mag(b, is_signed_s);
    prod_s      = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quo_s       = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_s       = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d  = op[1];
          neg_res_d = is_signed_s & (a[31] ^ b[31]);
          neg_rem_d = is_signed_s & a[31];
          divz_d    = op[1] & (b == 32'd0);
          a_org_d   = a;
          cnt_d     = 5'd0;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
          // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
          if (op[1]) begin
            acc_d  = {32'd0, a_mag_s};
            opnd_d = b_mag_s;
          end else begin
            acc_d  = {32'd0, b_mag_s};
            opnd_d = a_mag_s;
          end
        end else begin
          if (wr_hi) begin
            hi_d = wdata;
          end else begin
            hi_d = hi_q;
          end
          if (wr_lo) begin
            lo_d = wdata;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      ST_RUN: begin
        acc_d = step_acc_s;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MDU_STEPS - 1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FIX: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (!is_div_q) begin
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
        end else if (divz_q) begin
          hi_d = a_org_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem_s;
          lo_d = quo_s;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      busy_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      a_org_q   <= 32'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      a_org_q   <= a_org_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
